// File: rtl/histogram_axi_lite_if.sv
// AXI4-Lite read-only channel bundle (AR + R) for the histogram block.
interface histogram_axi_lite_if #(
  parameter int ADDR_BITS = 11
);
  logic [ADDR_BITS-1:0] s_axi_araddr;
  logic                 s_axi_arvalid;
  logic                 s_axi_arready;
  logic [31:0]          s_axi_rdata;
  logic [1:0]           s_axi_rresp;
  logic                 s_axi_rvalid;
  logic                 s_axi_rready;

  modport master (
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/histogram_axi_lite.sv
// One-frame luma histogram with an AXI4-Lite read-only register/bin window.
// Define HISTOGRAM_SAT_EN to make bins saturate and report a sticky overflow flag.
module histogram_axi_lite #(
  parameter int PIXEL_BITS = 8,
  parameter int COUNT_BITS = 24,
  parameter int ADDR_BITS  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PIXEL_BITS-1:0] y_i,
  input  logic                  dv_i,
  input  logic                  vs_i,
  input  logic                  cpu_trigger,
  output logic                  cpu_signal_done,
  histogram_axi_lite_if.slave   s_axi
);
  localparam int BINS      = 2 ** PIXEL_BITS;
  localparam int WORD_BITS = ADDR_BITS - 2;
  localparam logic [WORD_BITS-1:0] STATUS_IDX = WORD_BITS'(BINS);
  localparam logic [WORD_BITS-1:0] TOTAL_IDX  = WORD_BITS'(BINS + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_VS, ACCUM, FLUSH, DONE} state_t;

  state_t                  state;
  logic                    done;
  logic [PIXEL_BITS-1:0]   clr_idx;
  logic                    vs_q;
  logic                    vs_edge;
  logic                    busy;
  logic                    accept;
  logic [31:0]             pix_total;
  logic                    ovf;

  logic                    s0_valid, s1_valid, w_valid;
  logic [PIXEL_BITS-1:0]   s0_pix, s1_pix, w_pix;
  logic [COUNT_BITS-1:0]   w_data, rd_q, base, next_count;
  logic                    sat;
  logic [PIXEL_BITS-1:0]   rd_addr;
  logic [COUNT_BITS-1:0]   mem [BINS];

  logic                    ar_pend, ar_bins_ok;
  logic [WORD_BITS-1:0]    ar_word;
  logic [31:0]             rd_data;
  logic [1:0]              rd_resp;
  logic                    unused_addr_bits;

  assign vs_edge         = vs_i & ~vs_q;
  assign busy            = (state != IDLE) && (state != DONE);
  assign accept          = dv_i & (((state == ACCUM) & ~vs_edge) | ((state == WAIT_VS) & vs_edge));
  assign cpu_signal_done = done;
  assign unused_addr_bits = ^s_axi.s_axi_araddr[1:0];

  // The write of the previous pixel lands on the same edge as this pixel's RAM read, so forward it.
  assign base = (w_valid && (w_pix == s1_pix)) ? w_data : rd_q;
  assign sat  = &base;
`ifdef HISTOGRAM_SAT_EN
  assign next_count = sat ? base : base + COUNT_BITS'(1);
`else
  assign next_count = base + COUNT_BITS'(1);
  assign ovf        = 1'b0;
`endif

  // The single RAM read port belongs to the pixel pipe while busy and to AXI otherwise.
  assign rd_addr = busy ? s0_pix : s_axi.s_axi_araddr[PIXEL_BITS+1:2];

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (s1_valid) begin
      mem[s1_pix] <= next_count;
    end
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      clr_idx   <= '0;
      vs_q      <= 1'b0;
      pix_total <= '0;
`ifdef HISTOGRAM_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      vs_q <= vs_i;
      if (accept) pix_total <= pix_total + 32'd1;
`ifdef HISTOGRAM_SAT_EN
      if (s1_valid && sat) ovf <= 1'b1;
`endif
      case (state)
        IDLE, DONE: begin
          if (cpu_trigger) begin
            state     <= CLEAR;
            done      <= 1'b0;
            clr_idx   <= '0;
            pix_total <= '0;
`ifdef HISTOGRAM_SAT_EN
            ovf       <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + PIXEL_BITS'(1);
          if (&clr_idx) state <= WAIT_VS;
        end
        WAIT_VS: if (vs_edge) state <= ACCUM;
        ACCUM:   if (vs_edge) state <= FLUSH;
        FLUSH: begin
          if (!s0_valid && !s1_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      w_valid  <= 1'b0;
      s0_pix   <= '0;
      s1_pix   <= '0;
      w_pix    <= '0;
      w_data   <= '0;
    end else begin
      s0_valid <= accept;
      s0_pix   <= y_i;
      s1_valid <= s0_valid;
      s1_pix   <= s0_pix;
      w_valid  <= s1_valid;
      w_pix    <= s1_pix;
      w_data   <= next_count;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = 2'b10;
    if (ar_word[WORD_BITS-1:PIXEL_BITS] == '0) begin
      if (ar_bins_ok) begin
        rd_data = 32'(rd_q);
        rd_resp = 2'b00;
      end
    end else if (ar_word == STATUS_IDX) begin
      rd_data = {29'b0, ovf, done, busy};
      rd_resp = 2'b00;
    end else if (ar_word == TOTAL_IDX) begin
      rd_data = pix_total;
      rd_resp = 2'b00;
    end
  end

  // Bin permission is latched at acceptance, matching the cycle the RAM was actually read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi.s_axi_arready <= 1'b1;
      s_axi.s_axi_rvalid  <= 1'b0;
      s_axi.s_axi_rdata   <= '0;
      s_axi.s_axi_rresp   <= 2'b00;
      ar_pend             <= 1'b0;
      ar_bins_ok          <= 1'b0;
      ar_word             <= '0;
    end else begin
      if (s_axi.s_axi_arvalid && s_axi.s_axi_arready) begin
        s_axi.s_axi_arready <= 1'b0;
        ar_pend             <= 1'b1;
        ar_word             <= s_axi.s_axi_araddr[ADDR_BITS-1:2];
        ar_bins_ok          <= ~busy;
      end
      if (ar_pend) begin
        ar_pend            <= 1'b0;
        s_axi.s_axi_rvalid <= 1'b1;
        s_axi.s_axi_rdata  <= rd_data;
        s_axi.s_axi_rresp  <= rd_resp;
      end
      if (s_axi.s_axi_rvalid && s_axi.s_axi_rready) begin
        s_axi.s_axi_rvalid  <= 1'b0;
        s_axi.s_axi_arready <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_histogram_axi_lite.sv
// Scoreboard bench for histogram_axi_lite: a bench-side histogram model predicts every AXI read.
module tb_histogram_axi_lite;
  localparam int PIXEL_BITS = 8;
  localparam int COUNT_BITS = 4;
  localparam int ADDR_BITS  = 11;
  localparam int BINS       = 256;
  localparam int CMAX       = 15;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [PIXEL_BITS-1:0] y = '0;
  logic                  dv = 1'b0;
  logic                  vs = 1'b0;
  logic                  cpu_trigger = 1'b0;
  logic                  done;

  int          errors = 0;
  int          checks = 0;
  int          model_bins [BINS];
  logic [31:0] model_total = '0;
  logic        model_ovf = 1'b0;
  int          model_state = 0;
  exp_t        sb [$];

  always #5 clk = ~clk;

  histogram_axi_lite_if #(.ADDR_BITS(ADDR_BITS)) bus ();

  histogram_axi_lite #(
    .PIXEL_BITS(PIXEL_BITS),
    .COUNT_BITS(COUNT_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .y_i            (y),
    .dv_i           (dv),
    .vs_i           (vs),
    .cpu_trigger    (cpu_trigger),
    .cpu_signal_done(done),
    .s_axi          (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic countPixel(input int yv);
    if (model_state == 1) begin
`ifdef HISTOGRAM_SAT_EN
      if (model_bins[yv] == CMAX) model_ovf = 1'b1;
      else model_bins[yv] = model_bins[yv] + 1;
`else
      model_bins[yv] = (model_bins[yv] + 1) % (CMAX + 1);
`endif
      model_total = model_total + 32'd1;
    end
  endtask

  function automatic exp_t expectRead(input string tag, input int word);
    exp_t e;
    e.tag  = tag;
    e.data = '0;
    e.resp = 2'b10;
    if (word < BINS) begin
      if (model_state != 1) begin
        e.data = 32'(model_bins[word]);
        e.resp = 2'b00;
      end
    end else if (word == BINS) begin
      e.data = {29'b0, model_ovf, model_state == 2, model_state == 1};
      e.resp = 2'b00;
    end else if (word == BINS + 1) begin
      e.data = model_total;
      e.resp = 2'b00;
    end
    return e;
  endfunction

  task automatic triggerRun();
    cpu_trigger = 1'b1;
    step();
    cpu_trigger = 1'b0;
    foreach (model_bins[i]) model_bins[i] = 0;
    model_total = '0;
    model_ovf   = 1'b0;
    model_state = 1;
    repeat (BINS + 4) step();
  endtask

  task automatic openFrame(input int yv);
    vs = 1'b1;
    dv = 1'b1;
    y  = PIXEL_BITS'(yv);
    countPixel(yv);
    step();
    vs = 1'b0;
    dv = 1'b0;
  endtask

  task automatic applyStimulus(input int px [$]);
    foreach (px[i]) begin
      y  = PIXEL_BITS'(px[i]);
      dv = 1'b1;
      countPixel(px[i]);
      step();
    end
    dv = 1'b0;
  endtask

  // The pixel presented on the closing edge is deliberately not modelled.
  task automatic closeFrame(input string tag);
    int cyc;
    vs = 1'b1;
    dv = 1'b1;
    y  = 8'h05;
    step();
    vs = 1'b0;
    dv = 1'b0;
    cyc = 0;
    while (!done && cyc < 10) begin
      step();
      cyc++;
    end
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    model_state = 2;
  endtask

  task automatic axiRead(input string tag, input int word, input int hold);
    exp_t        got;
    int          cyc;
    logic [31:0] first;
    sb.push_back(expectRead(tag, word));
    bus.s_axi_araddr  = ADDR_BITS'(word << 2);
    bus.s_axi_arvalid = 1'b1;
    cyc = 0;
    while (!bus.s_axi_arready && cyc < 20) begin
      step();
      cyc++;
    end
    step();
    bus.s_axi_arvalid = 1'b0;
    checkOutput({tag, "_arready_drop"}, 32'(bus.s_axi_arready), 32'd0);
    step();
    checkOutput({tag, "_rvalid_t2"}, 32'(bus.s_axi_rvalid), 32'd1);
    cyc = 0;
    while (!bus.s_axi_rvalid && cyc < 10) begin
      step();
      cyc++;
    end
    got = sb.pop_front();
    checkOutput({got.tag, "_rdata"}, bus.s_axi_rdata, got.data);
    checkOutput({got.tag, "_rresp"}, 32'(bus.s_axi_rresp), 32'(got.resp));
    first = bus.s_axi_rdata;
    for (int i = 0; i < hold; i++) begin
      step();
      checkOutput({tag, "_hold_rdata"}, bus.s_axi_rdata, first);
      checkOutput({tag, "_hold_arready"}, 32'(bus.s_axi_arready), 32'd0);
      checkOutput({tag, "_hold_rvalid"}, 32'(bus.s_axi_rvalid), 32'd1);
    end
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_rready = 1'b0;
    checkOutput({tag, "_rvalid_end"}, 32'(bus.s_axi_rvalid), 32'd0);
    checkOutput({tag, "_arready_back"}, 32'(bus.s_axi_arready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int px [$];
    bus.s_axi_araddr  = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready  = 1'b0;
    foreach (model_bins[i]) model_bins[i] = 0;

    repeat (3) step();
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_arready", 32'(bus.s_axi_arready), 32'd1);
    checkOutput("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    checkOutput("rst_rdata", bus.s_axi_rdata, 32'd0);
    checkOutput("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
    rst_n = 1'b1;
    step();
    axiRead("idle_status", BINS, 0);
    axiRead("idle_total", BINS + 1, 0);

    $display("[TB] single-value frame");
    triggerRun();
    openFrame(5);
    px = {};
    repeat (9) px.push_back(5);
    applyStimulus(px);
    closeFrame("t1");
    axiRead("t1_bin5", 5, 0);
    axiRead("t1_bin0", 0, 0);
    axiRead("t1_bin4", 4, 0);
    axiRead("t1_bin255", 255, 0);
    axiRead("t1_total", BINS + 1, 0);
    axiRead("t1_status", BINS, 0);
    axiRead("t5_bin5_hold", 5, 5);

    $display("[TB] forwarding frame");
    triggerRun();
    openFrame(3);
    px = '{3, 3, 7, 3, 7};
    applyStimulus(px);
    closeFrame("t2");
    axiRead("t2_bin3", 3, 0);
    axiRead("t2_bin7", 7, 0);
    axiRead("t2_bin5", 5, 0);
    axiRead("t2_total", BINS + 1, 0);

    $display("[TB] reads while busy");
    triggerRun();
    openFrame(4);
    px = '{4, 8};
    applyStimulus(px);
    repeat (4) step();
    axiRead("t3_bin4_busy", 4, 0);
    axiRead("t3_status_busy", BINS, 0);
    axiRead("t3_total_busy", BINS + 1, 0);
    axiRead("t3_word300", 300, 0);
    closeFrame("t3");
    axiRead("t3_status", BINS, 0);
    axiRead("t3_bin4", 4, 0);
    axiRead("t3_word300_idle", 300, 0);

    $display("[TB] counter limit frame");
    triggerRun();
    openFrame(9);
    px = {};
    repeat (19) px.push_back(9);
    applyStimulus(px);
    closeFrame("t4");
    axiRead("t4_bin9", 9, 0);
    axiRead("t4_status", BINS, 0);
    axiRead("t4_total", BINS + 1, 0);

    $display("[TB] reset during accumulation");
    triggerRun();
    openFrame(9);
    px = '{9, 9};
    applyStimulus(px);
    bus.s_axi_araddr  = ADDR_BITS'(BINS << 2);
    bus.s_axi_arvalid = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    step();
    checkOutput("t6_rvalid_pre", 32'(bus.s_axi_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rvalid_rst", 32'(bus.s_axi_rvalid), 32'd0);
    checkOutput("t6_done_rst", 32'(done), 32'd0);
    checkOutput("t6_arready_rst", 32'(bus.s_axi_arready), 32'd1);
    model_state = 0;
    model_total = '0;
    model_ovf   = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    axiRead("t6_status_idle", BINS, 0);
    axiRead("t6_total_idle", BINS + 1, 0);
    triggerRun();
    openFrame(200);
    px = '{200, 200, 200};
    applyStimulus(px);
    closeFrame("t6");
    axiRead("t6_bin200", 200, 0);
    axiRead("t6_bin9", 9, 0);
    axiRead("t6_total", BINS + 1, 0);
    axiRead("t6_status", BINS, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
